// File: rtl/key_gen_if.sv
// Request/result bundle between the key generator and its host.
// The host drives start/p/q/e; the generator returns status and the key pair.
interface key_gen_if;
    logic       start;
    logic [3:0] p;
    logic [3:0] q;
    logic [8:0] e;
    logic       busy;
    logic       done;
    logic       key_valid;
    logic       key_error;
    logic [7:0] n;
    logic [7:0] d;

    modport slave (
        input  start, p, q, e,
        output busy, done, key_valid, key_error, n, d
    );

    modport master (
        output start, p, q, e,
        input  busy, done, key_valid, key_error, n, d
    );
endinterface

// File: rtl/key_gen.sv
// Toy RSA key generator: n = p*q, d = e^-1 mod (p-1)(q-1) found by linear search.
// Reduces e modulo phi by repeated subtraction, then steps acc = k*e mod phi until it hits 1.
module key_gen (
    input  logic     clk,
    input  logic     rst,
    key_gen_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        REDUCE = 3'd2,
        SEARCH = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] p_q, p_d, q_q, q_d;
    logic [8:0] e_q, e_d;
    logic [7:0] n_int_q, n_int_d;
    logic [7:0] phi_q, phi_d;
    logic [8:0] e_red_q, e_red_d;
    logic [7:0] d_cnt_q, d_cnt_d;
    logic [8:0] acc_q, acc_d;
    logic [7:0] n_q, n_d, d_q, d_d;
    logic       kv_q, kv_d, ke_q, ke_d;
    logic [9:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            n_int_q <= '0;
            phi_q   <= '0;
            e_red_q <= '0;
            d_cnt_q <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            kv_q    <= 1'b0;
            ke_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            e_q     <= e_d;
            n_int_q <= n_int_d;
            phi_q   <= phi_d;
            e_red_q <= e_red_d;
            d_cnt_q <= d_cnt_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            d_q     <= d_d;
            kv_q    <= kv_d;
            ke_q    <= ke_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        e_d     = e_q;
        n_int_d = n_int_q;
        phi_d   = phi_q;
        e_red_d = e_red_q;
        d_cnt_d = d_cnt_q;
        acc_d   = acc_q;
        n_d     = n_q;
        d_d     = d_q;
        kv_d    = kv_q;
        ke_d    = ke_q;
        // acc and e_red are both below phi (<=196), so the sum stays under 392
        sum     = {1'b0, acc_q} + {1'b0, e_red_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = bus.p;
                    q_d     = bus.q;
                    e_d     = bus.e;
                    kv_d    = 1'b0;
                    ke_d    = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                n_int_d = {4'd0, p_q} * {4'd0, q_q};
                phi_d   = ({4'd0, p_q} - 8'd1) * ({4'd0, q_q} - 8'd1);
                if (p_q < 4'd2 || q_q < 4'd2 || e_q == 9'd0) begin
                    n_d     = '0;
                    d_d     = '0;
                    kv_d    = 1'b0;
                    ke_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    e_red_d = e_q;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (e_red_q >= {1'b0, phi_q}) begin
                    e_red_d = e_red_q - {1'b0, phi_q};
                end else begin
                    d_cnt_d = 8'd1;
                    acc_d   = e_red_q;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (acc_q == 9'd1) begin
                    n_d     = n_int_q;
                    d_d     = d_cnt_q;
                    kv_d    = 1'b1;
                    ke_d    = 1'b0;
                    state_d = DONE;
                end else if (d_cnt_q == phi_q - 8'd1) begin
                    // exhausted every candidate: e and phi share a factor
                    n_d     = '0;
                    d_d     = '0;
                    kv_d    = 1'b0;
                    ke_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    d_cnt_d = d_cnt_q + 8'd1;
                    acc_d   = (sum >= {2'b00, phi_q}) ? 9'(sum - {2'b00, phi_q}) : sum[8:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == CALC) || (state_q == REDUCE) || (state_q == SEARCH);
    assign bus.done      = (state_q == DONE);
    assign bus.key_valid = kv_q;
    assign bus.key_error = ke_q;
    assign bus.n         = n_q;
    assign bus.d         = d_q;
endmodule

// File: tb/tb_key_gen.sv
// Bench for key_gen: directed spec cases, reset behaviour, held start, and random keys
// compared against a number-theoretic reference model.
module tb_key_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    key_gen_if kif();

    key_gen dut (.clk(clk), .rst(rst), .bus(kif.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] prev_n = 8'd0;
    logic [7:0] prev_d = 8'd0;

    // Reference: direct modular arithmetic, latency derived from the step counts.
    function automatic void model(input int p, input int q, input int e,
                                  output int lat, output bit ok, output int n, output int d);
        int phi, r, er, k;
        ok = 1'b0; n = 0; d = 0;
        if (p < 2 || q < 2 || e == 0) begin
            lat = 1;
            return;
        end
        phi = (p - 1) * (q - 1);
        r   = e / phi + 1;
        er  = e % phi;
        for (k = 1; k <= phi - 1; k++)
            if ((er * k) % phi == 1) break;
        if (k <= phi - 1) begin
            ok = 1'b1; n = p * q; d = k; lat = 1 + r + k;
        end else begin
            lat = 1 + r + phi - 1;
        end
    endfunction

    // Launches one run from just after a clock edge and waits for done (bounded).
    task automatic go(input logic [3:0] pp, input logic [3:0] qq, input logic [8:0] ee,
                      input logic [3:0] np, input logic [3:0] nq, input logic [8:0] ne,
                      input bit keep, output int lat, output int bcyc,
                      output logic kv0, output logic ke0, output logic [7:0] n0, output logic [7:0] d0);
        kif.p = pp; kif.q = qq; kif.e = ee; kif.start = 1'b1;
        @(posedge clk); #1;
        kv0 = kif.key_valid; ke0 = kif.key_error; n0 = kif.n; d0 = kif.d;
        kif.p = np; kif.q = nq; kif.e = ne;
        if (!keep) kif.start = 1'b0;
        lat = 0; bcyc = 0;
        while (kif.done !== 1'b1 && lat < 600) begin
            if (kif.busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (kif.done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        int lat;
        kif.start = 1'b0; kif.p = 4'd0; kif.q = 4'd0; kif.e = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({kif.busy, kif.done, kif.key_valid, kif.key_error, kif.n, kif.d} !== 20'h0) begin
            n_err++; $display("FAIL reset_state: got %h want 0",
                {kif.busy, kif.done, kif.key_valid, kif.key_error, kif.n, kif.d});
        end
        @(negedge clk);
        rst = 1'b1; kif.p = 4'd5; kif.q = 4'd7; kif.e = 9'd5; kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
        n_cmp++;
        if (kif.busy !== 1'b1) begin n_err++; $display("FAIL reset_first_edge_accept: busy=%b want 1", kif.busy); end
        lat = 0;
        while (kif.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 7 || kif.n !== 8'd35 || kif.d !== 8'd5) begin
            n_err++; $display("FAIL reset_first_run: lat=%0d n=%0d d=%0d want 7/35/5", lat, kif.n, kif.d);
        end
        prev_n = 8'd35; prev_d = 8'd5;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int tp[4]  = '{3, 5, 5, 1};
        int tq[4]  = '{11, 7, 7, 7};
        int te[4]  = '{3, 5, 300, 3};
        int tl[4]  = '{9, 7, 37, 1};
        int tv[4]  = '{1, 1, 0, 0};
        int tn[4]  = '{33, 35, 0, 0};
        int td[4]  = '{7, 5, 0, 0};
        int lat, bc;
        logic kv0, ke0;
        logic [7:0] n0, d0;
        for (int i = 0; i < 4; i++) begin
            go(4'(tp[i]), 4'(tq[i]), 9'(te[i]), 4'($urandom), 4'($urandom), 9'($urandom),
               1'b0, lat, bc, kv0, ke0, n0, d0);
            n_cmp++;
            if (kv0 !== 1'b0 || ke0 !== 1'b0 || n0 !== prev_n || d0 !== prev_d) begin
                n_err++; $display("FAIL dir%0d_start_clear: kv=%b ke=%b n=%0d d=%0d want 0 0 %0d %0d",
                    i, kv0, ke0, n0, d0, prev_n, prev_d);
            end
            n_cmp++;
            if (lat !== tl[i]) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            n_cmp++;
            if (bc !== tl[i]) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, tl[i]); end
            n_cmp++;
            if (kif.key_valid !== tv[i][0] || kif.key_error !== !tv[i][0] ||
                kif.n !== 8'(tn[i]) || kif.d !== 8'(td[i])) begin
                n_err++; $display("FAIL dir%0d_result: kv=%b ke=%b n=%0d d=%0d want kv=%0d n=%0d d=%0d",
                    i, kif.key_valid, kif.key_error, kif.n, kif.d, tv[i], tn[i], td[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (kif.done !== 1'b0 || kif.n !== 8'(tn[i]) || kif.d !== 8'(td[i]) || kif.key_valid !== tv[i][0]) begin
                n_err++; $display("FAIL dir%0d_hold: done=%b n=%0d d=%0d kv=%b", i, kif.done, kif.n, kif.d, kif.key_valid);
            end
            prev_n = 8'(tn[i]); prev_d = 8'(td[i]);
        end
    endtask

    task automatic test_reset_midrun;
        int seen;
        kif.p = 4'd3; kif.q = 4'd11; kif.e = 9'd3; kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if (kif.busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy_before_reset: busy=%b want 1", kif.busy); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({kif.busy, kif.done, kif.key_valid, kif.key_error, kif.n, kif.d} !== 20'h0) begin
            n_err++; $display("FAIL midrun_async_clear: got %h want 0",
                {kif.busy, kif.done, kif.key_valid, kif.key_error, kif.n, kif.d});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (kif.done === 1'b1 || kif.busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL midrun_no_done: active cycles=%0d want 0", seen); end
        prev_n = 8'd0; prev_d = 8'd0;
    endtask

    task automatic test_after_abort;
        int lat, bc;
        logic kv0, ke0;
        logic [7:0] n0, d0;
        go(4'd3, 4'd11, 9'd3, 4'd0, 4'd0, 9'd0, 1'b0, lat, bc, kv0, ke0, n0, d0);
        n_cmp++;
        if (lat !== 9 || kif.n !== 8'd33 || kif.d !== 8'd7 || kif.key_valid !== 1'b1) begin
            n_err++; $display("FAIL after_abort_run: lat=%0d n=%0d d=%0d kv=%b want 9/33/7/1",
                lat, kif.n, kif.d, kif.key_valid);
        end
        prev_n = 8'd33; prev_d = 8'd7;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic kv0, ke0;
        logic [7:0] n0, d0;
        go(4'd3, 4'd11, 9'd3, 4'd5, 4'd7, 9'd5, 1'b1, lat, bc, kv0, ke0, n0, d0);
        n_cmp++;
        if (lat !== 9 || kif.n !== 8'd33 || kif.d !== 8'd7) begin
            n_err++; $display("FAIL hold_first_run: lat=%0d n=%0d d=%0d want 9/33/7", lat, kif.n, kif.d);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (kif.busy !== 1'b0 || kif.done !== 1'b0 || kif.key_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_idle_gap: busy=%b done=%b kv=%b want 0 0 1", kif.busy, kif.done, kif.key_valid);
        end
        @(posedge clk); #1;
        kif.start = 1'b0;
        n_cmp++;
        if (kif.busy !== 1'b1 || kif.key_valid !== 1'b0 || kif.n !== 8'd33) begin
            n_err++; $display("FAIL hold_second_accept: busy=%b kv=%b n=%0d want 1 0 33", kif.busy, kif.key_valid, kif.n);
        end
        lat = 0;
        while (kif.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 7 || kif.n !== 8'd35 || kif.d !== 8'd5 || kif.key_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_second_run: lat=%0d n=%0d d=%0d kv=%b want 7/35/5/1", lat, kif.n, kif.d, kif.key_valid);
        end
        prev_n = 8'd35; prev_d = 8'd5;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int p, q, e, mlat, mn, md, lat, bc;
        bit ok;
        logic kv0, ke0;
        logic [7:0] n0, d0;
        for (int i = 0; i < 24; i++) begin
            do begin
                p = int'($urandom_range(0, 15));
                q = int'($urandom_range(0, 15));
            end while (p == 2 && q == 2);
            e = (i % 8 == 7) ? 0 : int'($urandom_range(1, 511));
            model(p, q, e, mlat, ok, mn, md);
            go(4'(p), 4'(q), 9'(e), 4'($urandom), 4'($urandom), 9'($urandom), 1'b0, lat, bc, kv0, ke0, n0, d0);
            n_cmp++;
            if (kv0 !== 1'b0 || ke0 !== 1'b0 || n0 !== prev_n || d0 !== prev_d) begin
                n_err++; $display("FAIL rnd%0d_start_clear: kv=%b ke=%b n=%0d d=%0d", i, kv0, ke0, n0, d0);
            end
            n_cmp++;
            if (lat !== mlat || kif.key_valid !== ok || kif.key_error !== !ok ||
                kif.n !== 8'(mn) || kif.d !== 8'(md)) begin
                n_err++; $display("FAIL rnd%0d p=%0d q=%0d e=%0d: lat=%0d kv=%b n=%0d d=%0d want lat=%0d kv=%0d n=%0d d=%0d",
                    i, p, q, e, lat, kif.key_valid, kif.n, kif.d, mlat, ok, mn, md);
            end
            prev_n = 8'(mn); prev_d = 8'(md);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.start = 1'b0; kif.p = 4'd0; kif.q = 4'd0; kif.e = 9'd0;
        test_reset();
        test_directed();
        test_reset_midrun();
        test_after_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_gen.md
KEY_GEN -- requirements
Module: key_gen

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request a key computation; sampled only in IDLE.
REQ-004 SHALL have port p  input  4  first prime, unsigned.
REQ-005 SHALL have port q  input  4  second prime, unsigned.
REQ-006 SHALL have port e  input  9  public exponent, unsigned.
REQ-007 SHALL have port busy  output  1  high in CALC, REDUCE and SEARCH.
REQ-008 SHALL have port done  output  1  one-cycle pulse; high exactly while in DONE.
REQ-009 SHALL have port key_valid  output  1  last computation produced a valid d.
REQ-010 SHALL have port key_error  output  1  last computation failed.
REQ-011 SHALL have port n  output  8  modulus p*q for the encrypt stage.
REQ-012 SHALL have port d  output  8  private exponent for the decrypt stage.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> REDUCE -> SEARCH -> DONE -> IDLE, one transition per clock edge at most.
REQ-014 SHALL, in IDLE with start=1, latch p, q and e internally and go to CALC; later changes on p, q or e SHALL NOT affect the run.
REQ-015 SHALL, in CALC, register n_int=p*q (8b) and phi=(p-1)*(q-1) (8b); if p<2, q<2 or e=0, go to DONE with error, else go to REDUCE with e_red=e.
REQ-016 SHALL, in REDUCE, when e_red>=phi, set e_red=e_red-phi and stay; else go to SEARCH with d_cnt=1 and acc=e_red (acc 9b).
REQ-017 SHALL, in SEARCH, when acc==1, go to DONE with success and result d_cnt.
REQ-018 SHALL, in SEARCH, when acc!=1 and d_cnt==phi-1, go to DONE with error (gcd(e,phi)!=1).
REQ-019 SHALL, in SEARCH otherwise, set d_cnt=d_cnt+1 and acc=acc+e_red, minus phi if the sum>=phi; all arithmetic SHALL be unsigned and free of overflow (sum<392).
REQ-020 SHALL, on entering DONE with success, set n=n_int, d=d_cnt, key_valid=1 and key_error=0.
REQ-021 SHALL, on entering DONE with error, set n=0, d=0, key_valid=0 and key_error=1.
REQ-022 SHALL hold n, d, key_valid and key_error stable from DONE until the next accepted start.
REQ-023 SHALL, at the next accepted start, clear key_valid and key_error; n and d SHALL then hold their old values until DONE.
REQ-024 SHALL ignore start outside IDLE, including in DONE; a start held high SHALL be accepted in the IDLE cycle that follows DONE.
REQ-025 SHALL, on a success path, raise done 1+R+d edges after the start-sampling edge, where R=floor(e/phi)+1.
REQ-026 SHALL, on a CALC error, raise done 1 edge after the start-sampling edge.
REQ-027 SHALL, on a SEARCH error, raise done 1+R+(phi-1) edges after the start-sampling edge.

Reset
REQ-028 SHALL, while rst=0 (asynchronously, regardless of clk), force state=IDLE and busy, done, key_valid, key_error, n, d and all internal registers to 0.
REQ-029 SHALL abort any computation when reset is asserted mid-run; no done pulse SHALL follow release.
REQ-030 SHALL, after rst rises, accept start from the first rising edge.

Verification
REQ-031 SHALL cover: p=3, q=11, e=3, start pulse -> done 9 edges later; n=33, d=7, key_valid=1, key_error=0.
REQ-032 SHALL cover: p=5, q=7, e=5 -> done 7 edges later; n=35, d=5, key_valid=1.
REQ-033 SHALL cover: p=5, q=7, e=300 (e_red=12, gcd!=1) -> done 37 edges later; key_error=1, n=0, d=0.
REQ-034 SHALL cover: p=1, q=7, e=3 -> done 1 edge later; key_error=1; busy high exactly one cycle.
REQ-035 SHALL cover: p=3, q=11, e=3, rst=0 asserted at edge 4 -> all outputs 0 immediately; no done; a new start after release completes normally.
REQ-036 SHALL cover: start held high throughout and p/q changed mid-run -> first result unaffected; second run starts the cycle after DONE.
